// File: rtl/mem_stage_pkg.sv
// Shared types and defaults for the memory-access stage of the 8-bit pipelined CPU.
// Holds the FSM state enum, the data loaded on a timed-out access, and the default widths.
package mem_stage_pkg;

   localparam int DEF_ADDR_W  = 8;
   localparam int DEF_DATA_W  = 8;
   localparam int DEF_REG_W   = 3;
   localparam int DEF_TIMEOUT = 15;

   // Value handed to writeback when a memory access is abandoned.
   localparam logic [7:0] ERR_DATA = 8'hFF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge port of the memory-access stage.
// The stage drives the master modport; the data memory (or a bench model) drives the slave modport.
interface mem_access_stage_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) ();

   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ack
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ack
   );

endinterface

// File: rtl/mem_timeout_ctr.sv
// Counts consecutive enabled cycles and flags the TIMEOUT-th one so the stage can abandon
// an access the memory never acknowledges. Only instantiated when MEM_TIMEOUT_EN is defined.
module mem_timeout_ctr
   import mem_stage_pkg::*;
#(
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic clk,
   input  logic rst,
   input  logic clear_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // The count saturates at LAST; the stage leaves BUSY on that cycle anyway.
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != LAST)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access stage: ALU ops pass straight through; loads/stores run a req/ack transaction
// while holding the pipeline with stall. Optional access timeout is enabled by MEM_TIMEOUT_EN.
module mem_access_stage
   import mem_stage_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int REG_W   = DEF_REG_W,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               memRd_IN,
   input  logic               memWr_IN,
   input  logic               regWr_IN,
   input  logic [DATA_W-1:0]  aluRes_IN,
   input  logic [DATA_W-1:0]  wrData_IN,
   input  logic [REG_W-1:0]   rd_IN,
   mem_access_stage_if.master mem,
   output logic               stall,
   output logic               memRd_OUT,
   output logic               regWr_OUT,
   output logic [DATA_W-1:0]  memReadData_OUT,
   output logic [DATA_W-1:0]  aluRes_OUT,
   output logic [REG_W-1:0]   rd_OUT
`ifdef MEM_TIMEOUT_EN
   ,
   output logic               mem_err
`endif
);

   state_e            state_q;
   state_e            state_d;
   logic [DATA_W-1:0] rdata_q;
   logic [DATA_W-1:0] rdata_d;
   logic              mem_op;
   logic              req;
   logic              expired;

   assign mem_op = memRd_IN | memWr_IN;

   // Request is combinational in IDLE so a same-cycle ack costs only one stall cycle.
   assign req = !rst && (((state_q == IDLE) && mem_op) || (state_q == BUSY));

`ifdef MEM_TIMEOUT_EN
   logic mem_err_q;
   logic mem_err_d;

   mem_timeout_ctr #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout_ctr (
      .clk       (clk),
      .rst       (rst),
      .clear_i   (state_q != BUSY),
      .en_i      (state_q == BUSY),
      .expired_o (expired)
   );

   assign mem_err = mem_err_q;
`else
   assign expired = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      rdata_d = rdata_q;
`ifdef MEM_TIMEOUT_EN
      mem_err_d = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (mem_op) begin
               if (mem.mem_ack) begin
                  if (memRd_IN) rdata_d = mem.mem_rdata;
                  state_d = DONE;
               end else begin
                  state_d = BUSY;
               end
            end
         end
         BUSY: begin
            // An ack on the expiry cycle still counts as a completed access.
            if (mem.mem_ack) begin
               if (memRd_IN) rdata_d = mem.mem_rdata;
               state_d = DONE;
            end else if (expired) begin
               rdata_d = DATA_W'(ERR_DATA);
`ifdef MEM_TIMEOUT_EN
               mem_err_d = 1'b1;
`endif
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         rdata_q   <= '0;
`ifdef MEM_TIMEOUT_EN
         mem_err_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         rdata_q   <= rdata_d;
`ifdef MEM_TIMEOUT_EN
         mem_err_q <= mem_err_d;
`endif
      end
   end

   // EX/MEM is frozen by stall, so address and data stay stable for the whole request.
   assign mem.mem_req   = req;
   assign mem.mem_we    = req & memWr_IN & ~memRd_IN;
   assign mem.mem_addr  = ADDR_W'(aluRes_IN);
   assign mem.mem_wdata = wrData_IN;

   // While stalled, MEM/WB must latch a bubble.
   assign stall           = req;
   assign memRd_OUT       = !rst && !req && memRd_IN;
   assign regWr_OUT       = !rst && !req && regWr_IN;
   assign memReadData_OUT = rst ? '0 : rdata_q;
   assign aluRes_OUT      = rst ? '0 : aluRes_IN;
   assign rd_OUT          = rst ? '0 : rd_IN;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: vector table, directed multi-cycle sequences and
// randomized transactions against a transaction-level model. Timeout case runs with MEM_TIMEOUT_EN.
module tb_mem_access_stage;
   import mem_stage_pkg::*;

   localparam int TB_TIMEOUT = 4;

   logic       clk;
   logic       rst;
   logic       memRd;
   logic       memWr;
   logic       regWr;
   logic [7:0] alu;
   logic [7:0] wd;
   logic [2:0] dst;
   logic       stall;
   logic       memRd_o;
   logic       regWr_o;
   logic [7:0] rdata_o;
   logic [7:0] alu_o;
   logic [2:0] rd_o;
`ifdef MEM_TIMEOUT_EN
   logic       mem_err;
`endif

   int         n_tests;
   int         n_fail;
   logic [7:0] model_rdata;

   mem_access_stage_if #(.ADDR_W(8), .DATA_W(8)) mif ();

   mem_access_stage #(
      .ADDR_W  (8),
      .DATA_W  (8),
      .REG_W   (3),
      .TIMEOUT (TB_TIMEOUT)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .memRd_IN        (memRd),
      .memWr_IN        (memWr),
      .regWr_IN        (regWr),
      .aluRes_IN       (alu),
      .wrData_IN       (wd),
      .rd_IN           (dst),
      .mem             (mif.master),
      .stall           (stall),
      .memRd_OUT       (memRd_o),
      .regWr_OUT       (regWr_o),
      .memReadData_OUT (rdata_o),
      .aluRes_OUT      (alu_o),
      .rd_OUT          (rd_o)
`ifdef MEM_TIMEOUT_EN
      ,
      .mem_err         (mem_err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rd;
      logic       wr;
      logic       rw;
      logic [7:0] alu;
      logic [7:0] wd;
      logic [2:0] dst;
      logic       e_stall;
      logic       e_req;
      logic       e_we;
      logic       e_mrd;
      logic       e_rwo;
   } vec_t;

   vec_t tbl [6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic w, input logic rw,
                        input logic [7:0] a, input logic [7:0] d, input logic [2:0] t);
      memRd = r;
      memWr = w;
      regWr = rw;
      alu   = a;
      wd    = d;
      dst   = t;
   endtask

   task automatic check_outs(input string tag, input logic e_stall, input logic e_req,
                             input logic e_we, input logic e_mrd, input logic e_rwo,
                             input logic [7:0] e_data, input logic [7:0] e_alu,
                             input logic [2:0] e_rd);
      check({tag, ".stall"}, stall, e_stall);
      check({tag, ".req"}, mif.mem_req, e_req);
      check({tag, ".we"}, mif.mem_we, e_we);
      check({tag, ".memRd_OUT"}, memRd_o, e_mrd);
      check({tag, ".regWr_OUT"}, regWr_o, e_rwo);
      check({tag, ".rdata_OUT"}, rdata_o, e_data);
      check({tag, ".aluRes_OUT"}, alu_o, e_alu);
      check({tag, ".rd_OUT"}, rd_o, e_rd);
   endtask

   // One instruction through the stage; the bench plays the memory and acks after n cycles.
   task automatic run_instr(input string tag, input logic r, input logic w, input logic rw,
                            input logic [7:0] a, input logic [7:0] d, input logic [2:0] t,
                            input int n, input logic [7:0] rdv);
      if (!(r | w)) begin
         @(negedge clk);
         drive(r, w, rw, a, d, t);
         mif.mem_ack   = 1'($urandom_range(0, 1));
         mif.mem_rdata = 8'($urandom);
         #1;
         check_outs({tag, ".alu"}, 1'b0, 1'b0, 1'b0, r, rw, model_rdata, a, t);
         @(posedge clk);
      end else begin
         for (int c = 0; c <= n; c++) begin
            @(negedge clk);
            drive(r, w, rw, a, d, t);
            mif.mem_ack   = (c == n);
            mif.mem_rdata = (c == n) ? rdv : 8'($urandom);
            #1;
            check_outs({tag, ".stallcyc"}, 1'b1, 1'b1, w & ~r, 1'b0, 1'b0, model_rdata, a, t);
            check({tag, ".addr"}, mif.mem_addr, a);
            check({tag, ".wdata"}, mif.mem_wdata, d);
            @(posedge clk);
         end
         if (r) model_rdata = rdv;
         @(negedge clk);
         mif.mem_ack   = 1'($urandom_range(0, 1));
         mif.mem_rdata = 8'($urandom);
         #1;
         check_outs({tag, ".done"}, 1'b0, 1'b0, 1'b0, r, rw, model_rdata, a, t);
         @(posedge clk);
      end
      $display("[TB] %s rd=%0b wr=%0b addr=%0h n=%0d rdata_model=%0h", tag, r, w, a, n, model_rdata);
   endtask

   initial begin
      n_tests       = 0;
      n_fail        = 0;
      model_rdata   = 8'h00;
      rst           = 1'b1;
      mif.mem_ack   = 1'b0;
      mif.mem_rdata = 8'h00;
      drive(1'b0, 1'b0, 1'b1, 8'h3C, 8'h12, 3'd5);

      tbl[0] = '{1'b0, 1'b0, 1'b1, 8'h3C, 8'h00, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[1] = '{1'b0, 1'b0, 1'b0, 8'h81, 8'h44, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[2] = '{1'b1, 1'b0, 1'b1, 8'h10, 8'h00, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[3] = '{1'b0, 1'b1, 1'b0, 8'h20, 8'h77, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[4] = '{1'b1, 1'b1, 1'b1, 8'h30, 8'h55, 3'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[5] = '{1'b0, 1'b0, 1'b1, 8'hFF, 8'h00, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

      // Reset holds everything at zero even with a live instruction on the inputs.
      @(negedge clk);
      #1;
      check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0);
      $display("[TB] reset state checked");
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         drive(tbl[i].rd, tbl[i].wr, tbl[i].rw, tbl[i].alu, tbl[i].wd, tbl[i].dst);
         mif.mem_ack   = 1'b1;
         mif.mem_rdata = 8'hC0 + 8'(i);
         #1;
         check_outs($sformatf("vec%0d", i), tbl[i].e_stall, tbl[i].e_req, tbl[i].e_we,
                    tbl[i].e_mrd, tbl[i].e_rwo, model_rdata, tbl[i].alu, tbl[i].dst);
         @(posedge clk);
         if (tbl[i].e_stall) begin
            if (tbl[i].rd) model_rdata = 8'hC0 + 8'(i);
            @(negedge clk);
            mif.mem_ack = 1'b0;
            #1;
            check_outs($sformatf("vec%0d.done", i), 1'b0, 1'b0, 1'b0, tbl[i].rd, tbl[i].rw,
                       model_rdata, tbl[i].alu, tbl[i].dst);
            @(posedge clk);
         end
         $display("[TB] vec%0d rd=%0b wr=%0b addr=%0h", i, tbl[i].rd, tbl[i].wr, tbl[i].alu);
      end

      run_instr("load2", 1'b1, 1'b0, 1'b1, 8'h10, 8'h00, 3'd2, 2, 8'hA5);
      run_instr("store0", 1'b0, 1'b1, 1'b0, 8'h20, 8'h77, 3'd0, 0, 8'h00);
      run_instr("b2b_a", 1'b1, 1'b0, 1'b1, 8'h31, 8'h00, 3'd1, 1, 8'h5C);
      run_instr("b2b_b", 1'b1, 1'b0, 1'b1, 8'h32, 8'h00, 3'd4, 1, 8'hE3);

      for (int i = 0; i < 200; i++) begin
         logic [2:0] ctl;
         ctl = 3'($urandom);
         run_instr($sformatf("rnd%0d", i), ctl[0] & ctl[2], ctl[1] & ctl[2], 1'($urandom),
                   8'($urandom), 8'($urandom), 3'($urandom), int'($urandom_range(0, 3)),
                   8'($urandom));
      end

      // Reset pulsed while the access is sitting in BUSY.
      @(negedge clk);
      drive(1'b1, 1'b0, 1'b1, 8'h40, 8'h00, 3'd3);
      mif.mem_ack = 1'b0;
      #1;
      check("rstmid.issue_req", mif.mem_req, 1'b1);
      @(posedge clk);
      @(negedge clk);
      #1;
      check("rstmid.busy_stall", stall, 1'b1);
      rst = 1'b1;
      model_rdata = 8'h00;
      #1;
      check_outs("rstmid.rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      drive(1'b0, 1'b0, 1'b1, 8'h99, 8'h00, 3'd2);
      mif.mem_ack   = 1'b1;
      mif.mem_rdata = 8'h5A;
      #1;
      check_outs("rstmid.after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h99, 3'd2);
      @(posedge clk);
      @(negedge clk);
      mif.mem_ack = 1'b0;
      #1;
      check("rstmid.late_ack_rdata", rdata_o, 8'h00);
      $display("[TB] reset mid-transaction checked");

`ifdef MEM_TIMEOUT_EN
      // Never acked: IDLE issue cycle plus TB_TIMEOUT BUSY cycles, then DONE with error data.
      for (int c = 0; c <= TB_TIMEOUT; c++) begin
         @(negedge clk);
         drive(1'b1, 1'b0, 1'b1, 8'h50, 8'h00, 3'd6);
         mif.mem_ack = 1'b0;
         #1;
         check($sformatf("tmo.stall%0d", c), stall, 1'b1);
         check($sformatf("tmo.err%0d", c), mem_err, 1'b0);
         @(posedge clk);
      end
      model_rdata = 8'hFF;
      @(negedge clk);
      mif.mem_ack   = 1'b1;
      mif.mem_rdata = 8'h33;
      #1;
      check("tmo.err_pulse", mem_err, 1'b1);
      check_outs("tmo.done", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, model_rdata, 8'h50, 3'd6);
      @(posedge clk);
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0);
      mif.mem_ack   = 1'b1;
      mif.mem_rdata = 8'h44;
      #1;
      check("tmo.err_clear", mem_err, 1'b0);
      check("tmo.late_ack_rdata", rdata_o, model_rdata);
      @(posedge clk);
      $display("[TB] timeout sequence checked");
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
